fht_input_loader: RTL and testbench
===================================

# fht_input_loader

Input frame loader sitting directly upstream of the FHT controller/datapath. Accepts a stream of real samples with valid/ready handshake, writes one full frame of N = 4·2^A_BIT points into the four input RAM banks in bit-reversed (FHT) order, then issues a one-cycle start pulse to the controller. It holds off new samples until the controller reports ready again.

## Interface
- A_BIT, 8: address width of one RAM bank; frame length N = 2^(A_BIT+2).
- D_BIT, 16: sample width.
- iCLK  in  1  clock.
- iRESET  in  1  reset, asynchronous, active-low.
- iDATA  in  D_BIT  input sample.
- iVALID  in  1  sample valid.
- oREADY  out  1  loader accepts a sample this cycle.
- iFHT_RDY  in  1  controller ready (idle/done) flag.
- iCLR_OVF  in  1  synchronous clear of oOVF.
- oWR_DATA  out  D_BIT  bank write data (shared by all banks).
- oWR_ADDR  out  A_BIT  bank write address (shared).
- oWE_0..oWE_3  out  1 each  bank write enables, at most one high.
- oSTART  out  1  one-cycle start pulse to controller.
- oBUSY  out  1  high from frame complete until controller done.
- oOVF  out  1  sticky: iVALID seen while oREADY low.

## Operation
- Sample index n: A_BIT+2 bit counter, 0 at reset and at each frame start; increments on each accepted sample (iVALID & oREADY).
- Storage index r = bitrev(n) over A_BIT+2 bits (with FHT_BIT_REV_EN). Bank = r[1:0], address = r[A_BIT+1:2].
- FSM states:
  - LOAD: oREADY = 1. On accept with n = N−1 → KICK.
  - KICK: oREADY = 0; lasts exactly one cycle, oSTART = 1 in the following cycle → WAIT_BUSY.
  - WAIT_BUSY: waits for iFHT_RDY = 0 → WAIT_DONE.
  - WAIT_DONE: waits for iFHT_RDY = 1 → LOAD, n = 0.
- Write port registered: accepted sample produces oWR_DATA/oWR_ADDR/oWE_k on the next cycle; WE outputs low in all other cycles.
- oBUSY = state ∈ {KICK, WAIT_BUSY, WAIT_DONE} or oSTART high.
- oOVF sets on iVALID & !oREADY; iCLR_OVF clears; set wins if both in the same cycle.
- Sample dropped when not accepted; no internal FIFO.
- n wraps from N−1 to 0 exactly at frame completion; no partial-frame start.

## Timing
- Reset values: oREADY = 1 (state LOAD), oWE_0..3 = 0, oWR_DATA = 0, oWR_ADDR = 0, oSTART = 0, oBUSY = 0, oOVF = 0, n = 0.
- Write latency: accept at cycle t → WE at t+1.
- Last sample accepted at t: WE at t+1, oREADY low from t+1, oSTART high at t+2 only.
- Controller ready drops no earlier than t+3; WAIT_BUSY ignores iFHT_RDY before it first goes low (no false completion).
- iFHT_RDY rising at cycle u → oREADY = 1 at u+1; first sample of next frame accepted no earlier than u+1.
- Reset asserted mid-frame: all state cleared immediately; partial frame discarded; no oSTART.
- iFHT_RDY level in LOAD is ignored.

## Configuration
- FHT_BIT_REV_EN defined: r = bitrev(n) as above.
- Undefined: r = n (natural order; bank = n[1:0], address = n[A_BIT+1:2]) for use when samples arrive pre-permuted; FSM and timing unchanged.

## Test plan
- A_BIT = 2 (N = 16), FHT_BIT_REV_EN on, continuous iVALID with iDATA = n: n = 1 → oWE_0, addr 2; n = 8 → oWE_1, addr 0; n = 3 → oWE_0, addr 3; all 16 locations written exactly once.
- Same frame: last sample at cycle t → oSTART high only at t+2, oREADY low from t+1; iFHT_RDY low 2 cycles then high at u → oREADY = 1 at u+1.
- iVALID held high during WAIT_DONE → no WE, oOVF = 1; iCLR_OVF pulse → oOVF = 0; iCLR_OVF coincident with new overflow → oOVF stays 1.
- Gapped iVALID (1 of 3 cycles) → addresses/banks identical to continuous case; oSTART once per 16 accepts.
- iRESET low after 7 samples → all outputs to reset values; next frame starts at n = 0, no oSTART until 16 further samples.
- FHT_BIT_REV_EN undefined, A_BIT = 2: n = 5 → oWE_1, addr 1; n = 15 → oWE_3, addr 3.

Source files
------------

// File: rtl/fht_input_loader.sv
// fht_input_loader
// ----------------
// Collects one frame of N = 2^(A_BIT+2) real samples from a valid/ready stream,
// writes them into the four FHT input RAM banks, pulses oSTART to the
// controller and then refuses samples until the controller reports done.
//
// Optional feature macro: FHT_BIT_REV_EN
//   defined   : storage index r = bitrev(n) over A_BIT+2 bits (FHT order)
//   undefined : storage index r = n (samples arrive already permuted)
// Bank = r[1:0], address = r[A_BIT+1:2].
//
// Ports
//   iCLK, iRESET      clock, asynchronous active-low reset
//   iDATA, iVALID     input sample stream
//   oREADY            sample accepted this cycle when iVALID is high
//   iFHT_RDY          controller idle/done flag
//   iCLR_OVF          synchronous clear of oOVF
//   oWR_DATA/ADDR     shared bank write port (registered, one cycle after accept)
//   oWE_0..oWE_3      per-bank write enables, at most one high
//   oSTART            one-cycle start pulse to the controller
//   oBUSY             frame handed over, controller not yet done
//   oOVF              sticky: a sample was offered while oREADY was low
module fht_input_loader #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    input  logic             iCLR_OVF,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic             oWE_0,
    output logic             oWE_1,
    output logic             oWE_2,
    output logic             oWE_3,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oOVF
);

    localparam int unsigned NBit = A_BIT + 2;

    typedef enum logic [1:0] {
        StLoad,
        StKick,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e           state_q, state_d;
    logic [NBit-1:0]  n_q, n_d;
    logic [NBit-1:0]  r;
    logic [3:0]       we_q, we_d;
    logic [A_BIT-1:0] wr_addr_q, wr_addr_d;
    logic [D_BIT-1:0] wr_data_q, wr_data_d;
    logic             start_q, start_d;
    logic             ovf_q, ovf_d;
    logic             ready;
    logic             accept;

    // Ready is a pure decode of the state register, so it never depends on inputs.
    assign ready  = (state_q == StLoad);
    assign accept = iVALID & ready;

    // Storage index for the current sample.
    always_comb begin
        r = n_q;
`ifdef FHT_BIT_REV_EN
        for (int i = 0; i < int'(NBit); i++) begin
            r[i] = n_q[int'(NBit) - 1 - i];
        end
`endif
    end

    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        we_d      = 4'b0000;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;

        if (accept) begin
            // Counter wraps from N-1 to 0 exactly on the last sample of a frame.
            n_d       = n_q + 1'b1;
            we_d[r[1:0]] = 1'b1;
            wr_addr_d = r[NBit-1:2];
            wr_data_d = iDATA;
        end

        unique case (state_q)
            StLoad: begin
                if (accept && (n_q == '1)) begin
                    state_d = StKick;
                end
            end
            StKick: begin
                start_d = 1'b1;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                // Controller may still show its old "ready" here; only a drop counts.
                if (!iFHT_RDY) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (iFHT_RDY) begin
                    state_d = StLoad;
                    n_d     = '0;
                end
            end
            default: state_d = StLoad;
        endcase

        // Set wins over clear.
        if (iVALID && !ready) begin
            ovf_d = 1'b1;
        end else if (iCLR_OVF) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_q   <= StLoad;
            n_q       <= '0;
            we_q      <= 4'b0000;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            ovf_q     <= ovf_d;
        end
    end

    assign oREADY   = ready;
    assign oWR_DATA = wr_data_q;
    assign oWR_ADDR = wr_addr_q;
    assign oWE_0    = we_q[0];
    assign oWE_1    = we_q[1];
    assign oWE_2    = we_q[2];
    assign oWE_3    = we_q[3];
    assign oSTART   = start_q;
    assign oBUSY    = (state_q != StLoad) | start_q;
    assign oOVF     = ovf_q;

endmodule

// File: tb/tb_fht_input_loader.sv
// Testbench for fht_input_loader with A_BIT = 2 (N = 16).
// Stimulus task predicts writes/starts from the frame rules and queues them;
// a negedge monitor pops and compares whenever the DUT writes or starts.
module tb_fht_input_loader;

    localparam int A_BIT = 2;
    localparam int D_BIT = 16;
    localparam int NBIT  = A_BIT + 2;
    localparam int N     = 1 << NBIT;

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic [D_BIT-1:0] iDATA = '0;
    logic             iVALID = 1'b0;
    logic             oREADY;
    logic             iFHT_RDY = 1'b1;
    logic             iCLR_OVF = 1'b0;
    logic [D_BIT-1:0] oWR_DATA;
    logic [A_BIT-1:0] oWR_ADDR;
    logic             oWE_0, oWE_1, oWE_2, oWE_3;
    logic             oSTART, oBUSY, oOVF;

    fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .iFHT_RDY (iFHT_RDY),
        .iCLR_OVF (iCLR_OVF),
        .oWR_DATA (oWR_DATA),
        .oWR_ADDR (oWR_ADDR),
        .oWE_0    (oWE_0),
        .oWE_1    (oWE_1),
        .oWE_2    (oWE_2),
        .oWE_3    (oWE_3),
        .oSTART   (oSTART),
        .oBUSY    (oBUSY),
        .oOVF     (oOVF)
    );

    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc <= cyc + 1;

    typedef struct {
        int bank;
        int addr;
        int data;
    } wr_t;

    wr_t wq[$];
    int  sq[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    int n_m      = 0;
    bit ready_m  = 1'b1;
    bit ovf_m    = 1'b0;
    bit seen_low = 1'b0;
    int frames   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int store_idx(input int n);
        int r;
`ifdef FHT_BIT_REV_EN
        r = 0;
        for (int i = 0; i < NBIT; i++) r = r * 2 + ((n >> i) & 1);
`else
        r = n;
`endif
        return r;
    endfunction

    // Monitor: compare every write and start against the scoreboard.
    always @(negedge iCLK) begin
        if (iRESET) begin
            int we;
            we = {28'd0, oWE_3, oWE_2, oWE_1, oWE_0};
            if (we != 0) begin
                chk("we_onehot", $countones(we), 1);
                if (wq.size() == 0) begin
                    chk("unexpected_write", we, 0);
                end else begin
                    wr_t e;
                    int  bank;
                    e = wq.pop_front();
                    bank = oWE_0 ? 0 : oWE_1 ? 1 : oWE_2 ? 2 : 3;
                    chk("wr_bank", bank, e.bank);
                    chk("wr_addr", int'(oWR_ADDR), e.addr);
                    chk("wr_data", int'(oWR_DATA), e.data);
                end
            end
            if (oSTART) begin
                if (sq.size() == 0) chk("unexpected_start", cyc, -1);
                else chk("start_cycle", cyc, sq.pop_front());
            end
        end
    end

    // One clock cycle of stimulus plus model update.
    task automatic step(input bit v, input int d, input bit rdy, input bit clr);
        bit nxt_ovf;
        bit nxt_ready;
        @(posedge iCLK);
        #1;
        iVALID   = v;
        iDATA    = d[D_BIT-1:0];
        iFHT_RDY = rdy;
        iCLR_OVF = clr;
        chk("ready", int'(oREADY), int'(ready_m));
        chk("busy", int'(oBUSY), int'(!ready_m));
        chk("ovf", int'(oOVF), int'(ovf_m));

        nxt_ovf   = (v && !ready_m) ? 1'b1 : (clr ? 1'b0 : ovf_m);
        nxt_ready = ready_m;
        if (v && ready_m) begin
            wr_t e;
            int  r;
            r = store_idx(n_m);
            e.bank = r % 4;
            e.addr = r / 4;
            e.data = d & 16'hFFFF;
            wq.push_back(e);
            n_m++;
            if (n_m == N) begin
                n_m       = 0;
                nxt_ready = 1'b0;
                seen_low  = 1'b0;
                sq.push_back(cyc + 2);
                frames++;
            end
        end else if (!ready_m) begin
            if (!rdy) seen_low = 1'b1;
            else if (seen_low) nxt_ready = 1'b1;
        end
        ready_m = nxt_ready;
        ovf_m   = nxt_ovf;
    endtask

    // mode 0: continuous, data = n; 1: valid 1 of 3; 2: random valid.
    task automatic run_frame(input int mode, input bit ovf_dir);
        int f0;
        int i;
        int lo;
        f0 = frames;
        i  = 0;
        while (frames == f0) begin
            bit v;
            int d;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (i % 3 == 0) : bit'($urandom_range(0, 1));
            d = (mode == 0) ? n_m : int'($urandom_range(0, 65535));
            step(v, d, 1'b1, 1'b0);
            i++;
            if (i > 500) begin
                chk("frame_timeout", i, 0);
                return;
            end
        end
        // Controller still shows ready for two cycles: must not count as done.
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        if (ovf_dir) begin
            step(1'b1, 1, 1'b0, 1'b0);
            step(1'b1, 2, 1'b0, 1'b1);
            step(1'b0, 3, 1'b0, 1'b1);
            step(1'b0, 4, 1'b0, 1'b0);
        end else begin
            lo = int'($urandom_range(2, 4));
            for (int k = 0; k < lo; k++) begin
                step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b0,
                     bit'($urandom_range(0, 3) == 0));
            end
        end
        // Controller done: loader ready again one cycle later.
        step(bit'($urandom_range(0, 1)), int'($urandom_range(0, 65535)), 1'b1, 1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_ready", int'(oREADY), 1);
        chk("rst_we", int'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        chk("rst_data", int'(oWR_DATA), 0);
        chk("rst_addr", int'(oWR_ADDR), 0);
        chk("rst_start", int'(oSTART), 0);
        chk("rst_busy", int'(oBUSY), 0);
        chk("rst_ovf", int'(oOVF), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        check_reset_values();
        @(posedge iCLK);
        #3;
        iRESET = 1'b1;

        run_frame(0, 1'b1);
        run_frame(1, 1'b0);
        run_frame(0, 1'b0);

        // Mid-frame reset after 7 samples; partial frame must be discarded.
        for (int k = 0; k < 7; k++) step(1'b1, int'($urandom_range(0, 65535)), 1'b1, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        @(negedge iCLK);
        #1;
        chk("pre_reset_drain", wq.size(), 0);
        iRESET = 1'b0;
        #2;
        check_reset_values();
        n_m     = 0;
        ready_m = 1'b1;
        ovf_m   = 1'b0;
        @(posedge iCLK);
        #3;
        iRESET = 1'b1;

        run_frame(2, 1'b0);
        run_frame(2, 1'b0);
        run_frame(1, 1'b0);

        for (int k = 0; k < 4; k++) step(1'b0, 0, 1'b1, 1'b0);
        @(negedge iCLK);
        #1;
        chk("writes_drained", wq.size(), 0);
        chk("starts_drained", sq.size(), 0);
        chk("frames_done", frames, 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
